// File: rtl/action_fetch.sv
// rtl/action_fetch.sv - match-to-action stage: action RAM lookup, PHV alignment, 3-deep output FIFO
// Feeds the per-stage crossbar under valid/ready; ready_out never depends on ready_in.
module action_fetch #(
  parameter int STAGE_ID   = 0,
  parameter int PHV_LEN    = 2304,
  parameter int ACT_LEN    = 64,
  parameter int C_NUM_PHVS = 65,
  parameter int ACT_DEPTH  = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PHV_LEN-1:0]            phv_in,
  input  logic                          phv_in_valid,
  input  logic                          match_hit,
  input  logic [ADDR_W-1:0]             match_addr,
  output logic                          ready_out,
  input  logic                          cfg_wr_en,
  input  logic [ADDR_W-1:0]             cfg_wr_addr,
  input  logic [ACT_LEN*C_NUM_PHVS-1:0] cfg_wr_data,
  output logic [PHV_LEN-1:0]            phv_out,
  output logic                          phv_out_valid,
  output logic [ACT_LEN*C_NUM_PHVS-1:0] action_out,
  output logic                          action_out_valid,
  input  logic                          ready_in
);

  localparam int AW    = ACT_LEN * C_NUM_PHVS;
  localparam int IDX_W = (ACT_DEPTH > 1) ? $clog2(ACT_DEPTH) : 1;

  logic [AW-1:0]      mem [ACT_DEPTH];
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic               rd_in_range;
  logic               wr_in_range;
  logic               accept;

  logic               s1_valid;
  logic               s1_hit;
  logic [PHV_LEN-1:0] s1_phv;
  logic [AW-1:0]      s1_act;

  logic [PHV_LEN-1:0] fifo_phv [3];
  logic [AW-1:0]      fifo_act [3];
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_ptr;
  logic [1:0]         count;
  logic               push;
  logic               pop;

  assign rd_idx = IDX_W'(match_addr);
  assign wr_idx = IDX_W'(cfg_wr_addr);

  // When the RAM covers the whole address space every address is in range.
  if (ACT_DEPTH >= (1 << ADDR_W)) begin : g_full_range
    assign rd_in_range = 1'b1;
    assign wr_in_range = 1'b1;
  end else begin : g_part_range
    assign rd_in_range = (match_addr  < ADDR_W'(ACT_DEPTH));
    assign wr_in_range = (cfg_wr_addr < ADDR_W'(ACT_DEPTH));
  end

  assign ready_out = (3'(count) + 3'(s1_valid)) < 3'd3;
  assign accept    = phv_in_valid && ready_out;

  // Read-first: a same-cycle write lands after the read samples the old word.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && wr_in_range) begin
      mem[wr_idx] <= cfg_wr_data;
    end
    if (accept) begin
      s1_act <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_phv   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_phv <= phv_in;
        s1_hit <= match_hit && rd_in_range;
      end
    end
  end

  assign push = s1_valid;
  assign pop  = (count != 2'd0) && ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        fifo_phv[i] <= '0;
        fifo_act[i] <= '0;
      end
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_phv[wr_ptr] <= s1_phv;
        fifo_act[wr_ptr] <= s1_hit ? s1_act : '0;
        wr_ptr           <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign phv_out          = fifo_phv[rd_ptr];
  assign action_out       = fifo_act[rd_ptr];
  assign phv_out_valid    = (count != 2'd0);
  assign action_out_valid = phv_out_valid;

endmodule

// File: tb/tb_action_fetch.sv
// tb/tb_action_fetch.sv - directed bench for action_fetch
// Built with ADDR_W=5 so out-of-range match addresses can be driven.
module tb_action_fetch;

  localparam int PHV_LEN = 2304;
  localparam int ACT_LEN = 64;
  localparam int CN      = 65;
  localparam int AW      = ACT_LEN * CN;
  localparam int ADDR_W  = 5;

  typedef struct {
    int            tag;
    logic [AW-1:0] act;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic [PHV_LEN-1:0] phv_in;
  logic               phv_in_valid;
  logic               match_hit;
  logic [ADDR_W-1:0]  match_addr;
  logic               ready_out;
  logic               cfg_wr_en;
  logic [ADDR_W-1:0]  cfg_wr_addr;
  logic [AW-1:0]      cfg_wr_data;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_out_valid;
  logic [AW-1:0]      action_out;
  logic               action_out_valid;
  logic               ready_in;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  int   pop_cycles[$];

  logic [AW-1:0] w5, wa, wb, zero_act;

  action_fetch #(
    .STAGE_ID(0), .PHV_LEN(PHV_LEN), .ACT_LEN(ACT_LEN), .C_NUM_PHVS(CN),
    .ACT_DEPTH(16), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .phv_in(phv_in), .phv_in_valid(phv_in_valid),
    .match_hit(match_hit), .match_addr(match_addr), .ready_out(ready_out),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .phv_out(phv_out), .phv_out_valid(phv_out_valid), .action_out(action_out),
    .action_out_valid(action_out_valid), .ready_in(ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PHV_LEN-1:0] mk_phv(input int tag);
    logic [PHV_LEN-1:0] p;
    p = '0;
    p[31:0]        = ~tag[31:0];
    p[2047:2016]   = 32'hDEADBEEF;
    p[2079:2048]   = tag[31:0];
    p[2303:2272]   = 32'hA5A50000 | tag[31:0];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [AW-1:0] d);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = a;
    cfg_wr_data = d;
    tick();
    cfg_wr_en   = 1'b0;
  endtask

  task automatic send(input int tag, input logic hit, input logic [ADDR_W-1:0] addr,
                      input logic [AW-1:0] exp_act);
    int n;
    n            = 0;
    phv_in       = mk_phv(tag);
    phv_in_valid = 1'b1;
    match_hit    = hit;
    match_addr   = addr;
    while (!ready_out && n < 100) begin
      tick();
      n++;
    end
    if (!ready_out) begin
      check("send_timeout", 64'(ready_out), 64'd1);
    end else begin
      exp_q.push_back('{tag, exp_act});
      tick();
    end
    phv_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || phv_out_valid) && n < 200) begin
      tick();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Output scoreboard: every pop must match the oldest accepted PHV.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && phv_out_valid && ready_in) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_tag", 64'(phv_out[2079:2048]), 64'(e.tag));
          check("out_phv_eq", 64'(phv_out == mk_phv(e.tag)), 64'd1);
          check("out_act_sub1", action_out[127:64], e.act[127:64]);
          check("out_act_eq", 64'(action_out == e.act), 64'd1);
          check("out_act_valid", 64'(action_out_valid), 64'd1);
          pop_cycles.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int p0, nxt, acc;
    w5 = '0;
    w5[127:64]     = 64'h0100_0400_0000_0000;
    w5[AW-1:AW-64] = 64'h1111_2222_3333_4444;
    wa = '0;
    wa[63:0]       = 64'hAAAA_AAAA_AAAA_AAAA;
    wa[127:64]     = 64'h0A0A_0A0A_0A0A_0A0A;
    wb = '0;
    wb[63:0]       = 64'hBBBB_BBBB_BBBB_BBBB;
    wb[127:64]     = 64'h0B0B_0B0B_0B0B_0B0B;
    zero_act       = '0;

    rst_n        = 1'b0;
    phv_in       = '0;
    phv_in_valid = 1'b0;
    match_hit    = 1'b0;
    match_addr   = '0;
    cfg_wr_en    = 1'b0;
    cfg_wr_addr  = '0;
    cfg_wr_data  = '0;
    ready_in     = 1'b1;
    repeat (3) tick();

    check("rst_phv_valid", 64'(phv_out_valid), 64'd0);
    check("rst_act_valid", 64'(action_out_valid), 64'd0);
    check("rst_ready_out", 64'(ready_out), 64'd1);
    check("rst_phv_zero", 64'(phv_out == '0), 64'd1);
    check("rst_act_zero", 64'(action_out == '0), 64'd1);
    rst_n = 1'b1;
    tick();

    // hit path and two-cycle latency
    cfg_write(5'd5, w5);
    send(1, 1'b1, 5'd5, w5);
    check("lat_t1_valid", 64'(phv_out_valid), 64'd0);
    tick();
    check("lat_t2_valid", 64'(phv_out_valid), 64'd1);
    check("lat_t2_c63", 64'(phv_out[2047:2016]), 64'hDEADBEEF);
    wait_drain();

    // miss, then hit with an address beyond the RAM depth (aliases entry 5)
    send(2, 1'b0, 5'd5, zero_act);
    send(3, 1'b1, 5'd21, zero_act);
    wait_drain();

    // streaming
    p0 = pop_cycles.size();
    for (int i = 1; i <= 20; i++) begin
      check("stream_ready", 64'(ready_out), 64'd1);
      send(i, 1'b1, 5'd5, w5);
    end
    wait_drain();
    check("stream_count", 64'(pop_cycles.size() - p0), 64'd20);
    if (pop_cycles.size() >= p0 + 20)
      check("stream_span", 64'(pop_cycles[p0+19] - pop_cycles[p0]), 64'd19);

    // back-pressure
    ready_in = 1'b0;
    nxt = 1;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      phv_in       = mk_phv(nxt);
      phv_in_valid = 1'b1;
      match_hit    = 1'b1;
      match_addr   = 5'd5;
      if (ready_out) begin
        exp_q.push_back('{nxt, w5});
        nxt++;
        acc++;
      end
      tick();
    end
    phv_in_valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'd3);
    check("bp_ready_low", 64'(ready_out), 64'd0);
    check("bp_head_valid", 64'(phv_out_valid), 64'd1);
    check("bp_head_tag", 64'(phv_out[2079:2048]), 64'd1);
    repeat (3) tick();
    check("bp_hold_tag", 64'(phv_out[2079:2048]), 64'd1);
    check("bp_hold_act", action_out[127:64], 64'h0100_0400_0000_0000);
    p0 = pop_cycles.size();
    ready_in = 1'b1;
    while (nxt <= 5) begin
      send(nxt, 1'b1, 5'd5, w5);
      nxt++;
    end
    wait_drain();
    check("bp_total", 64'(pop_cycles.size() - p0), 64'd5);

    // write/read collision on the same address
    cfg_write(5'd2, wa);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 5'd2;
    cfg_wr_data = wb;
    send(50, 1'b1, 5'd2, wa);
    cfg_wr_en   = 1'b0;
    send(51, 1'b1, 5'd2, wb);
    wait_drain();

    // reset with three entries queued
    ready_in = 1'b0;
    send(60, 1'b1, 5'd5, w5);
    send(61, 1'b1, 5'd5, w5);
    send(62, 1'b1, 5'd5, w5);
    repeat (2) tick();
    check("pre_rst_ready", 64'(ready_out), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(phv_out_valid), 64'd0);
    check("rst_async_ready", 64'(ready_out), 64'd1);
    check("rst_async_phv", 64'(phv_out == '0), 64'd1);
    exp_q.delete();
    tick();
    rst_n    = 1'b1;
    ready_in = 1'b1;
    tick();
    send(70, 1'b1, 5'd5, w5);
    check("post_rst_t1", 64'(phv_out_valid), 64'd0);
    tick();
    check("post_rst_t2", 64'(phv_out_valid), 64'd1);
    check("post_rst_act", action_out[127:64], 64'h0100_0400_0000_0000);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/action_fetch.md
# action_fetch

Match-to-action stage sitting directly upstream of the per-stage crossbar. Accepts a PHV plus its match result, reads the per-container action word from an internal configurable action RAM, aligns the PHV with that action and presents both to the crossbar under a valid/ready handshake. A 3-entry output FIFO absorbs crossbar back-pressure, so the stage sustains one PHV per cycle when `ready_in` stays high.

## Interface
- `STAGE_ID`, 0, pipeline stage index (informational only)
- `PHV_LEN`, 2304, PHV width: 64×32-bit containers plus 256 metadata bits
- `ACT_LEN`, 64, per-container sub-action width
- `C_NUM_PHVS`, 65, sub-actions per action word; action word = `ACT_LEN*C_NUM_PHVS` bits
- `ACT_DEPTH`, 16, action RAM entries
- `ADDR_W`, 4, action RAM address width

Ports:
- `clk` in 1: single clock; all logic on posedge
- `rst_n` in 1: reset, asynchronous and active-low
- `phv_in` in `PHV_LEN`: incoming PHV
- `phv_in_valid` in 1: `phv_in`/`match_*` valid
- `match_hit` in 1: lookup hit
- `match_addr` in `ADDR_W`: action RAM index on hit
- `ready_out` out 1: stage can accept this cycle
- `cfg_wr_en` in 1: action RAM write strobe
- `cfg_wr_addr` in `ADDR_W`: write index
- `cfg_wr_data` in `ACT_LEN*C_NUM_PHVS`: action word
- `phv_out` out `PHV_LEN`: PHV to crossbar
- `phv_out_valid` out 1: PHV valid
- `action_out` out `ACT_LEN*C_NUM_PHVS`: action word to crossbar
- `action_out_valid` out 1: always equal to `phv_out_valid`
- `ready_in` in 1: crossbar accepts this cycle

## Operation
- Accept: `phv_in_valid && ready_out` in cycle t. Never drop or duplicate an accepted PHV.
- S1 (registered, cycle t+1):
  - Action RAM read of `match_addr`; read-first.
  - `phv_in` and the effective hit registered alongside; `s1_valid` set.
  - Effective hit = `match_hit && match_addr < ACT_DEPTH`.
- Push (end of cycle t+1): FIFO entry = {S1 PHV, effective hit ? RAM data : all-zero action}. The all-zero word is the crossbar's passthrough/no-op opcode.
- FIFO: 3 entries, circular read/write pointers, 2-bit count.
  - Push when `s1_valid`; pop when `phv_out_valid && ready_in`.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap 2→0.
- Outputs:
  - `phv_out`/`action_out` = FIFO head; `phv_out_valid` = (count != 0).
  - Head data must stay stable while valid and not popped.
- Flow control: `ready_out = (count + s1_valid) < 3`, combinational from registers only, with no path from `ready_in`. This guarantees a push never finds the FIFO full.
- Config writes:
  - `cfg_wr_en` writes `cfg_wr_data` to `cfg_wr_addr` at the clock edge.
  - `cfg_wr_addr >= ACT_DEPTH` is ignored.
  - A write and a read to the same address in the same cycle: the read returns the old word.
  - Writes are independent of the handshake.
- Action RAM contents are not cleared by reset. Unwritten entries are undefined; the control plane must program them before use.

## Timing
- Reset (async assert, sync-safe deassert):
  - `s1_valid`=0, count=0, pointers=0, all FIFO entries zero.
  - Outputs: `phv_out_valid`=0, `action_out_valid`=0, `phv_out`=0, `action_out`=0, `ready_out`=1.
- Reset mid-operation flushes S1 and the FIFO; in-flight PHVs are lost.
- Latency: accepted in cycle t → visible on outputs in cycle t+2 when the FIFO was empty.
- Throughput: 1 PHV/cycle with `ready_in`=1 (steady state count=1, `s1_valid`=1, `ready_out`=1).
- Back-pressure:
  - With `ready_in`=0, at most 3 PHVs are accepted before `ready_out`=0: count 2 + S1 1, then count 3.
  - `ready_out` returns to 1 the cycle after the first pop reduces count + `s1_valid` below 3.

## Test plan
- Hit path: program addr 5 with word having sub-action 1 = 0x0100_0400_0000_0000. Send PHV with container 63 = 0xDEADBEEF, `match_hit`=1, addr 5. Expect `phv_out` identical and `action_out` = that word, with `phv_out_valid` exactly 2 cycles after accept.
- Miss / out-of-range: send `match_hit`=0, then `match_hit`=1 with `ACT_DEPTH`=16 and addr ≥ 16 (build with `ADDR_W`=5). Expect `action_out`=0 both times, PHVs in order.
- Streaming: 20 back-to-back PHVs tagged 1..20 in metadata with `ready_in`=1. Expect `ready_out` constantly 1 and 20 outputs in consecutive cycles, in order.
- Back-pressure: `ready_in`=0 while driving 5 PHVs. Expect exactly 3 accepted, `ready_out`=0 afterwards, outputs held stable. Raise `ready_in`: tags 1..5 emerge in order, none lost or repeated.
- Config collision: write addr 2 = A, then in the same cycle write addr 2 = B and accept PHV hitting addr 2. Expect `action_out`=A; the next PHV hitting addr 2 gets B.
- Reset mid-stream: assert `rst_n`=0 with 3 entries queued. Expect `phv_out_valid`=0 and `ready_out`=1 immediately (async). After release, the next PHV appears at t+2 with previously programmed RAM data intact.
